ddr_sdram_ex_lfsr_multi: RTL and testbench

Multi-lane, width- and polynomial-parametrised Galois LFSR pattern generator with a built-in pattern checker, for the DDR SDRAM example driver. Each byte/word lane runs an independent LFSR with a distinct seed. The write path uses the generated data. The read path compares returned data against the same sequence and keeps sticky per-lane error flags plus saturating error and word counters.

---
 rtl/ddr_sdram_ex_lfsr_multi_pkg.sv | 32 +++
 rtl/ddr_sdram_ex_lfsr_multi_if.sv | 31 +++
 rtl/ddr_sdram_ex_lfsr_multi_lane.sv | 47 ++++
 rtl/ddr_sdram_ex_lfsr_multi.sv | 84 ++++++++
 tb/tb_ddr_sdram_ex_lfsr_multi.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_sdram_ex_lfsr_multi_pkg.sv
// Shared constants and helpers for the multi-lane LFSR pattern generator/checker.
// Lane widths up to 32 bits are supported by the helper functions.
package ddr_sdram_ex_lfsr_pkg;

  localparam logic [7:0]  POLY_8  = 8'h1D;         // x^8+x^4+x^3+x^2+1
  localparam logic [15:0] POLY_16 = 16'h100B;      // x^16+x^12+x^3+x+1
  localparam logic [31:0] POLY_32 = 32'h0040_0007; // x^32+x^22+x^2+x+1

  // Lane k seed: (seed + k) truncated to width bits; zero is not a legal LFSR state.
  function automatic logic [31:0] lane_seed(int seed, int k, int width);
    logic [63:0] mask;
    logic [63:0] s;
    mask = (64'd1 << width) - 64'd1;
    s    = (64'(unsigned'(seed)) + 64'(unsigned'(k))) & mask;
    if (s == 64'd0) s = 64'd1;
    return s[31:0];
  endfunction

  // One Galois step: the MSB feeds bit 0 and is XORed into every tapped bit.
  function automatic logic [31:0] lfsr_next(logic [31:0] cur, logic [31:0] poly, int width);
    logic        m;
    logic [31:0] nxt;
    m      = cur[5'(width - 1)];
    nxt    = '0;
    nxt[0] = m;
    for (int i = 1; i < 32; i++) begin
      if (i < width) nxt[i] = cur[i-1] ^ (poly[i] & m);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ddr_sdram_ex_lfsr_multi_if.sv
// Pattern bus between the example driver (master) and the LFSR generator/checker (slave).
interface ddr_sdram_ex_lfsr_multi_if #(
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
);
  logic                          enable;
  logic                          pause;
  logic                          load;
  logic [NUM_LANES*LANE_W-1:0]   ldata;
  logic [NUM_LANES*LANE_W-1:0]   data;
  // check_valid is a one-way qualifier with no ready: the checker accepts check_data
  // in every cycle where enable && check_valid, and data must hold the expected word then.
  logic                          check_valid;
  logic [NUM_LANES*LANE_W-1:0]   check_data;
  logic                          err_clr;
  logic [NUM_LANES-1:0]          err_lane;
  logic                          err_any;
  logic [CNT_W-1:0]              err_count;
  logic [CNT_W-1:0]              word_count;

  modport master (
    output enable, pause, load, ldata, check_valid, check_data, err_clr,
    input  data, err_lane, err_any, err_count, word_count
  );

  modport slave (
    input  enable, pause, load, ldata, check_valid, check_data, err_clr,
    output data, err_lane, err_any, err_count, word_count
  );
endinterface

// File: rtl/ddr_sdram_ex_lfsr_multi_lane.sv
// One LFSR lane: seed/load/advance/hold priority with zero-load substitution.
module ddr_sdram_ex_lfsr_lane
  import ddr_sdram_ex_lfsr_pkg::*;
#(
  parameter int                LANE_W = 8,
  parameter logic [LANE_W-1:0] POLY   = 8'h1D,
  parameter logic [LANE_W-1:0] SEED_L = 8'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              pause_i,
  input  logic              load_i,
  input  logic [LANE_W-1:0] ldata_i,
  output logic [LANE_W-1:0] data_o
);

  logic [LANE_W-1:0] state_q;
  logic [LANE_W-1:0] state_d;
  logic [LANE_W-1:0] step_w;
  logic [31:0]       step32;
  logic              step_unused;

  assign step32      = lfsr_next(32'(state_q), 32'(POLY), LANE_W);
  assign step_w      = step32[LANE_W-1:0];
  assign step_unused = ^step32;

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = SEED_L;
    end else if (load_i) begin
      // An all-zero load would freeze the lane forever, so fall back to the seed.
      state_d = (ldata_i == '0) ? SEED_L : ldata_i;
    end else if (!pause_i) begin
      state_d = step_w;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEED_L;
    else          state_q <= state_d;
  end

  assign data_o = state_q;

endmodule

// File: rtl/ddr_sdram_ex_lfsr_multi.sv
// Multi-lane LFSR pattern generator with registered read-back checker,
// sticky per-lane error flags and saturating error/word counters.
module ddr_sdram_ex_lfsr_multi
  import ddr_sdram_ex_lfsr_pkg::*;
#(
  parameter int                LANE_W    = 8,
  parameter int                NUM_LANES = 4,
  parameter logic [LANE_W-1:0] POLY      = 8'h1D,
  parameter int                SEED      = 32,
  parameter int                CNT_W     = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  ddr_sdram_ex_lfsr_multi_if.slave bus
);

  localparam int               DW      = NUM_LANES * LANE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]        data_w;
  logic [NUM_LANES-1:0] mismatch_w;
  logic                 check_en_w;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [31:0] SEED32 = lane_seed(SEED, k, LANE_W);

    ddr_sdram_ex_lfsr_lane #(
      .LANE_W (LANE_W),
      .POLY   (POLY),
      .SEED_L (SEED32[LANE_W-1:0])
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable_i (bus.enable),
      .pause_i  (bus.pause),
      .load_i   (bus.load),
      .ldata_i  (bus.ldata[k*LANE_W +: LANE_W]),
      .data_o   (data_w[k*LANE_W +: LANE_W])
    );

    assign mismatch_w[k] = data_w[k*LANE_W +: LANE_W] != bus.check_data[k*LANE_W +: LANE_W];
  end

  assign check_en_w = bus.enable && bus.check_valid;

  logic [NUM_LANES-1:0] err_lane_q, err_lane_d;
  logic                 err_any_q,  err_any_d;
  logic [CNT_W-1:0]     err_cnt_q,  err_cnt_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;

  // Clear is applied first so a check in the same cycle is still accounted.
  always_comb begin
    err_lane_d = bus.err_clr ? '0 : err_lane_q;
    err_cnt_d  = bus.err_clr ? '0 : err_cnt_q;
    word_cnt_d = bus.err_clr ? '0 : word_cnt_q;
    if (check_en_w) begin
      err_lane_d = err_lane_d | mismatch_w;
      if (word_cnt_d != CNT_MAX)                  word_cnt_d = word_cnt_d + 1'b1;
      if ((mismatch_w != '0) && (err_cnt_d != CNT_MAX)) err_cnt_d = err_cnt_d + 1'b1;
    end
    err_any_d = |err_lane_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_lane_q <= '0;
      err_any_q  <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      err_lane_q <= err_lane_d;
      err_any_q  <= err_any_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.data       = data_w;
  assign bus.err_lane   = err_lane_q;
  assign bus.err_any    = err_any_q;
  assign bus.err_count  = err_cnt_q;
  assign bus.word_count = word_cnt_q;

endmodule

// File: tb/tb_ddr_sdram_ex_lfsr_multi.sv
// Directed bench for the multi-lane LFSR generator/checker: two instances,
// default counters and a 4-bit counter variant for saturation.
module tb_ddr_sdram_ex_lfsr_multi;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  ddr_sdram_ex_lfsr_multi_if #(.LANE_W(8), .NUM_LANES(4), .CNT_W(16)) if1 ();
  ddr_sdram_ex_lfsr_multi_if #(.LANE_W(8), .NUM_LANES(4), .CNT_W(4))  if2 ();

  ddr_sdram_ex_lfsr_multi #(
    .LANE_W(8), .NUM_LANES(4), .POLY(8'h1D), .SEED(32), .CNT_W(16)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1.slave)
  );

  ddr_sdram_ex_lfsr_multi #(
    .LANE_W(8), .NUM_LANES(4), .POLY(8'h1D), .SEED(32), .CNT_W(4)
  ) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if2.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference step written directly from x^8+x^4+x^3+x^2+1 (Galois form).
  function automatic logic [31:0] step_all(input logic [31:0] v);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      b = v[k*8 +: 8];
      b = b[7] ? ({b[6:0], 1'b0} ^ 8'h1D) : {b[6:0], 1'b0};
      r[k*8 +: 8] = b;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    if1.enable = 1'b0; if1.pause = 1'b0; if1.load = 1'b0; if1.ldata = '0;
    if1.check_valid = 1'b0; if1.check_data = '0; if1.err_clr = 1'b0;
    if2.enable = 1'b0; if2.pause = 1'b0; if2.load = 1'b0; if2.ldata = '0;
    if2.check_valid = 1'b0; if2.check_data = '0; if2.err_clr = 1'b0;
  endtask

  initial begin
    logic [31:0]  exp;
    logic [255:0] seen;
    logic [7:0]   v;
    logic         period_ok;
    logic         model_ok;

    checks = 0;
    errors = 0;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_data",       64'(if1.data),       64'h23222120);
    check("rst_err_lane",   64'(if1.err_lane),   64'h0);
    check("rst_err_any",    64'(if1.err_any),    64'h0);
    check("rst_err_count",  64'(if1.err_count),  64'h0);
    check("rst_word_count", 64'(if1.word_count), 64'h0);

    reset_n = 1'b1;
    tick();
    check("disabled_seed", 64'(if1.data), 64'h23222120);

    // First steps of lane 0
    if1.enable = 1'b1;
    tick(); check("lane0_step1", 64'(if1.data[7:0]), 64'h40);
    tick(); check("lane0_step2", 64'(if1.data[7:0]), 64'h80);
    tick(); check("lane0_step3", 64'(if1.data[7:0]), 64'h1D);
    tick(); check("lane0_step4", 64'(if1.data[7:0]), 64'h3A);

    if1.enable = 1'b0;
    tick();
    check("reseed", 64'(if1.data), 64'h23222120);

    // Full period from seed: 255 distinct nonzero values, then back to the seed
    if1.enable = 1'b1;
    seen      = '0;
    seen[8'h20] = 1'b1;
    period_ok = 1'b1;
    model_ok  = 1'b1;
    exp       = 32'h23222120;
    for (int i = 1; i <= 255; i++) begin
      tick();
      exp = step_all(exp);
      v   = if1.data[7:0];
      if (if1.data !== exp) model_ok = 1'b0;
      if (i < 255) begin
        if (v == 8'h00 || seen[v]) period_ok = 1'b0;
        seen[v] = 1'b1;
      end
    end
    check("period_unique", 64'(period_ok), 64'h1);
    check("period_model",  64'(model_ok),  64'h1);
    check("period_wrap",   64'(if1.data),  64'h23222120);

    // Pause holds
    if1.pause = 1'b1;
    tick(); check("pause_1", 64'(if1.data), 64'h23222120);
    tick(); check("pause_2", 64'(if1.data), 64'h23222120);
    tick(); check("pause_3", 64'(if1.data), 64'h23222120);
    if1.pause = 1'b0;

    // Load with zero-lane substitution
    if1.load  = 1'b1;
    if1.ldata = 32'h00FF0001;
    tick(); check("load_value", 64'(if1.data), 64'h23FF2101);
    if1.load = 1'b0;
    tick(); check("load_step",  64'(if1.data), 64'h46E34202);
    exp = 32'h46E34202;

    // Loopback of 10 good words
    if1.check_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if1.check_data = exp;
      tick();
      exp = step_all(exp);
    end
    check("loop_word_count", 64'(if1.word_count), 64'd10);
    check("loop_err_count",  64'(if1.err_count),  64'd0);
    check("loop_err_any",    64'(if1.err_any),    64'd0);
    check("loop_data_track", 64'(if1.data),       64'(exp));

    // Lane 1 corrupted once
    if1.check_data = exp ^ 32'h0000_5500;
    tick();
    exp = step_all(exp);
    check("bad_word_count", 64'(if1.word_count), 64'd11);
    check("bad_err_count",  64'(if1.err_count),  64'd1);
    check("bad_err_lane",   64'(if1.err_lane),   64'b0010);
    check("bad_err_any",    64'(if1.err_any),    64'd1);

    // Clear together with a mismatch on lanes 0 and 3
    if1.err_clr    = 1'b1;
    if1.check_data = exp ^ 32'h8000_0001;
    tick();
    exp = step_all(exp);
    check("clr_chk_err_count",  64'(if1.err_count),  64'd1);
    check("clr_chk_word_count", 64'(if1.word_count), 64'd1);
    check("clr_chk_err_lane",   64'(if1.err_lane),   64'b1001);
    check("clr_chk_err_any",    64'(if1.err_any),    64'd1);

    // Clear alone
    if1.check_valid = 1'b0;
    tick();
    exp = step_all(exp);
    check("clr_err_count",  64'(if1.err_count),  64'd0);
    check("clr_word_count", 64'(if1.word_count), 64'd0);
    check("clr_err_lane",   64'(if1.err_lane),   64'd0);
    check("clr_err_any",    64'(if1.err_any),    64'd0);
    if1.err_clr = 1'b0;

    // Lane 2 error, then enable=0: data reseeds, errors retained, checker idle
    if1.check_valid = 1'b1;
    if1.check_data  = exp ^ 32'h0010_0000;
    tick();
    check("l2_err_lane", 64'(if1.err_lane), 64'b0100);
    if1.enable     = 1'b0;
    if1.check_data = 32'h0;
    tick();
    check("dis_data",       64'(if1.data),       64'h23222120);
    check("dis_err_lane",   64'(if1.err_lane),   64'b0100);
    check("dis_err_any",    64'(if1.err_any),    64'd1);
    check("dis_word_count", 64'(if1.word_count), 64'd1);
    check("dis_err_count",  64'(if1.err_count),  64'd1);

    // 4-bit counters: 20 mismatching words (lanes are never zero)
    if2.enable      = 1'b1;
    if2.check_valid = 1'b1;
    if2.check_data  = 32'h0;
    for (int i = 0; i < 10; i++) tick();
    check("sat_mid_word_count", 64'(if2.word_count), 64'd10);
    check("sat_mid_err_count",  64'(if2.err_count),  64'd10);
    for (int i = 0; i < 10; i++) tick();
    check("sat_word_count", 64'(if2.word_count), 64'd15);
    check("sat_err_count",  64'(if2.err_count),  64'd15);
    check("sat_err_lane",   64'(if2.err_lane),   64'b1111);

    // Asynchronous reset mid-operation
    if1.enable = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_data",       64'(if1.data),       64'h23222120);
    check("arst_err_lane",   64'(if1.err_lane),   64'd0);
    check("arst_err_any",    64'(if1.err_any),    64'd0);
    check("arst_err_count",  64'(if1.err_count),  64'd0);
    check("arst_word_count", 64'(if1.word_count), 64'd0);
    check("arst_sat_count",  64'(if2.err_count),  64'd0);

    idle_inputs();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
